// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative HI/LO multiply/divide unit for MULT/MULTU/DIV/DIVU.
//            It executes one bit per cycle and also services MTHI/MTLO writes.
//            Define MULDIV_DIV_EN to build the divide datapath.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] numberA,
   input  logic [WIDTH-1:0] numberB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_FIX  = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_p;        // upper product half / partial remainder
   logic [WIDTH-1:0]   r_q;        // multiplier, then lower product half / quotient
   logic [WIDTH-1:0]   r_m;        // multiplicand / divisor magnitude
   logic               r_sign_q;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;

   logic               w_op_ok;
   logic               w_accept;
   logic               w_step;
   logic               w_fix;

   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;

`ifdef MULDIV_DIV_EN
   logic               r_is_div;
   logic               r_sign_r;
   logic [WIDTH-1:0]   r_a_raw;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic               w_div_ok;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_op_ok = 1'b1;
`else
   // Without the divide datapath, DIV/DIVU requests are simply not accepted.
   assign w_op_ok = ~op[1];
`endif

   assign w_accept = start & w_op_ok & (r_state == c_IDLE);

   // Signed ops work on magnitudes; the sign is re-applied in FIX.
   assign w_neg_a = ~op[0] & numberA[WIDTH-1];
   assign w_neg_b = ~op[0] & numberB[WIDTH-1];
   assign w_mag_a = w_neg_a ? (~numberA + 1'b1) : numberA;
   assign w_mag_b = w_neg_b ? (~numberB + 1'b1) : numberB;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_nxt = c_RUN;
         c_RUN:   if (r_cnt == c_LAST) w_state_nxt = c_FIX;
         c_FIX:   w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_step = 1'b0;
      w_fix  = 1'b0;
      case (r_state)
         c_RUN:   w_step = 1'b1;
         c_FIX:   w_fix  = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   assign w_mul_sum  = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
   assign w_prod     = {r_p, r_q};
   assign w_prod_fix = r_sign_q ? (~w_prod + 1'b1) : w_prod;

`ifdef MULDIV_DIV_EN
   // Restoring step: bit WIDTH of the difference is the borrow.
   assign w_div_shift = {r_p, r_q[WIDTH-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_m};
   assign w_div_ok    = ~w_div_diff[WIDTH];
   assign w_quo_fix   = r_sign_q ? (~r_q + 1'b1) : r_q;
   assign w_rem_fix   = r_sign_r ? (~r_p + 1'b1) : r_p;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt    <= '0;
         r_p      <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_sign_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_is_div <= 1'b0;
         r_sign_r <= 1'b0;
         r_a_raw  <= '0;
`endif
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_p      <= '0;
         r_q      <= w_mag_a;
         r_m      <= w_mag_b;
         r_sign_q <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
         r_is_div <= op[1];
         r_sign_r <= w_neg_a;
         r_a_raw  <= numberA;
`endif
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
`ifdef MULDIV_DIV_EN
         if (r_is_div) begin
            r_p <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], w_div_ok};
         end else begin
            r_p <= w_mul_sum[WIDTH:1];
            r_q <= {w_mul_sum[0], r_q[WIDTH-1:1]};
         end
`else
         r_p <= w_mul_sum[WIDTH:1];
         r_q <= {w_mul_sum[0], r_q[WIDTH-1:1]};
`endif
      end
   end

   // HI/LO: written by FIX or by MTHI/MTLO while idle (including the done cycle).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_fix) begin
`ifdef MULDIV_DIV_EN
         if (r_is_div) begin
            if (r_m == '0) begin
               r_hi <= r_a_raw;
               r_lo <= '1;
            end else begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end
         end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
         end
`else
         r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
         r_lo <= w_prod_fix[WIDTH-1:0];
`endif
      end else if (r_state == c_IDLE) begin
         if (hiWrite) r_hi <= writeData;
         if (loWrite) r_lo <= writeData;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != c_IDLE);
         r_done <= w_fix;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS core's HI/LO register pair. It executes MULT, MULTU, DIV and DIVU on the same 32-bit operand buses that feed the combinational ALU, one bit per cycle. It provides a start/busy/done handshake so the control path can stall the core until HI/LO are valid. It also services MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO.

## Interface
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request an operation; sampled only while idle.
- op  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- numberA  in  WIDTH  multiplicand / dividend (rs).
- numberB  in  WIDTH  multiplier / divisor (rt).
- hiWrite  in  1  MTHI strobe.
- loWrite  in  1  MTLO strobe.
- writeData  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start: latch op and operand magnitudes, then clear the iteration counter.
  - RUN: performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps -> FIX.
  - FIX: applies sign correction, writes HI/LO and asserts done. Then -> IDLE.
- Signed ops (MULT, DIV) take absolute values at start and negate at FIX.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- MULT/MULTU: {hi, lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder.
- Divide by zero, both DIV and DIVU: lo = all ones, hi = numberA as latched. No exception is raised.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while busy is ignored; operands must not be re-sampled.
- hiWrite/loWrite:
  - In IDLE: update hi/lo with writeData at the next edge.
  - While busy: ignored.
  - Simultaneous with an accepted start: the write takes effect, and the operation result overwrites it at FIX.
- Operand buses are sampled only at the start edge and may change afterward.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately. Next cycle: IDLE, busy=0, done=0, hi=lo=0, and no done pulse for the aborted op.
- Start accepted at edge E0.
  - busy is high from after E0 through the cycle containing edge E(WIDTH+1).
  - busy is low, and done and new hi/lo are visible, after E(WIDTH+1).
  - Latency is 33 cycles for WIDTH=32.
- done is high exactly one cycle. busy=0 during that cycle, and a new start may be accepted in that same cycle (back-to-back).
- busy is registered; no combinational path from start to busy.
- hi/lo change only at FIX, at an IDLE write, or at reset.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above, including DIV/DIVU.
- Not defined: the divide datapath is not compiled.
  - start with op DIV or DIVU is ignored: stays IDLE, busy=0, no done, hi/lo unchanged.
  - MULT/MULTU timing is unchanged.

## Test plan
- MULTU with numberA=0xFFFFFFFF, numberB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT with numberA=0xFFFFFFFD (-3), numberB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV with -7 and 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Without MULDIV_DIV_EN: DIVU start gives no busy, no done, hi/lo unchanged.
- Start MULTU 3*4, then assert start with different operands at cycles 5 and 20, plus hiWrite=1 writeData=0xDEADBEEF at cycle 10 -> all ignored; result hi=0, lo=12.
- Start DIV 100/7, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A following DIVU 100/7 -> lo=14, hi=2.
- In IDLE: hiWrite with 0x12345678, then loWrite with 0x9ABCDEF0 -> hi/lo update the next edge. Then back-to-back MULTU ops, the second start in the done cycle of the first -> both results correct with no lost cycle.
